// File: rtl/serial_subtract.sv
// -----------------------------------------------------------------------------
// serial_subtract
//   Bit-serial unsigned subtractor (LSB first) built from a single
//   full-subtract cell plus a borrow flop. Handshake: start is sampled in
//   IDLE, busy is high for WIDTH cycles, then done pulses for one cycle with
//   diff/bout/zero/ovf registered and held until the next result.
//
//   Optional build macro: SERIAL_SUBTRACT_OVF_EN
//     defined   -> ovf reports two's-complement signed overflow of a-b
//     undefined -> ovf tied to 0, no MSB capture or overflow logic
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   operation request, sampled only in IDLE
//   a      in   WIDTH-bit minuend, captured on accepted start
//   b      in   WIDTH-bit subtrahend, captured on accepted start
//   busy   out  high while bits are being processed
//   done   out  one-cycle pulse when results become valid
//   diff   out  registered a-b modulo 2^WIDTH
//   bout   out  final borrow (a < b unsigned)
//   zero   out  diff == 0, held with the result
//   ovf    out  signed overflow flag (0 unless SERIAL_SUBTRACT_OVF_EN)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module serial_subtract #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero,
  output logic             ovf
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Working registers
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Output registers
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             zero_q, zero_d;

  // Full-subtract cell on the current LSBs
  logic             bit_d;
  logic             br_nx;
  logic [WIDTH-1:0] res_shift;

  assign bit_d     = sa_q[0] ^ sb_q[0] ^ br_q;
  assign br_nx     = (~sa_q[0] & sb_q[0]) | (~(sa_q[0] ^ sb_q[0]) & br_q);
  // Working result after this cycle's bit enters at the MSB
  assign res_shift = {bit_d, res_q[WIDTH-1:1]};

`ifdef SERIAL_SUBTRACT_OVF_EN
  logic a_msb_q, a_msb_d;
  logic b_msb_q, b_msb_d;
  logic ovf_q, ovf_d;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = ST_SHIFT;
      ST_SHIFT: if (cnt_q == LAST_BIT) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    sa_d   = sa_q;
    sb_d   = sb_q;
    res_d  = res_q;
    br_d   = br_q;
    cnt_d  = cnt_q;
    diff_d = diff_q;
    bout_d = bout_q;
    zero_d = zero_q;
`ifdef SERIAL_SUBTRACT_OVF_EN
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d   = ovf_q;
`endif
    // busy/done are registered decodes of the upcoming state
    busy_d = (state_d == ST_SHIFT);
    done_d = (state_d == ST_DONE);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          sa_d  = a;
          sb_d  = b;
          res_d = '0;
          br_d  = 1'b0;
          cnt_d = '0;
`ifdef SERIAL_SUBTRACT_OVF_EN
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
`endif
        end
      end
      ST_SHIFT: begin
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        res_d = res_shift;
        br_d  = br_nx;
        cnt_d = cnt_q + CW'(1);
        // Results land on the last shift edge so they are valid with done
        if (cnt_q == LAST_BIT) begin
          diff_d = res_shift;
          bout_d = br_nx;
          zero_d = (res_shift == '0);
`ifdef SERIAL_SUBTRACT_OVF_EN
          ovf_d  = (a_msb_q != b_msb_q) && (bit_d != a_msb_q);
`endif
        end
      end
      default: begin
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sa_q   <= '0;
      sb_q   <= '0;
      res_q  <= '0;
      br_q   <= 1'b0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      sa_q   <= sa_d;
      sb_q   <= sb_d;
      res_q  <= res_d;
      br_q   <= br_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
      diff_q <= diff_d;
      bout_q <= bout_d;
      zero_q <= zero_d;
    end
  end

`ifdef SERIAL_SUBTRACT_OVF_EN
  // Operand sign capture and overflow flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
  assign zero = zero_q;

endmodule

// File: tb/tb_serial_subtract.sv
// -----------------------------------------------------------------------------
// tb_serial_subtract
//   Directed bench for serial_subtract at WIDTH=8. Outputs are sampled on the
//   falling edge; inputs are driven on the falling edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_serial_subtract;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
  logic         zero;
  logic         ovf;

  int errors = 0;
  int checks = 0;

  serial_subtract #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout),
    .zero  (zero),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef SERIAL_SUBTRACT_OVF_EN
  localparam bit OVF_ON = 1'b1;
`else
  localparam bit OVF_ON = 1'b0;
`endif

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [W-1:0] e_diff,
                          input logic e_bout, input logic e_zero, input logic e_ovf);
    chk({tag, ".diff"}, 16'(diff), 16'(e_diff));
    chk({tag, ".bout"}, 16'(bout), 16'(e_bout));
    chk({tag, ".zero"}, 16'(zero), 16'(e_zero));
    chk({tag, ".ovf"},  16'(ovf),  16'(e_ovf));
  endtask

  // One operation with a single-cycle start; called on a falling edge.
  task automatic op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                    input logic [W-1:0] e_diff, input logic e_bout,
                    input logic e_zero, input logic e_ovf);
    start = 1'b1; a = av; b = bv;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < int'(W); i++) begin
      chk({tag, ".busy"}, 16'(busy), 16'd1);
      chk({tag, ".early_done"}, 16'(done), 16'd0);
      @(negedge clk);
    end
    chk({tag, ".done"}, 16'(done), 16'd1);
    chk({tag, ".busy_end"}, 16'(busy), 16'd0);
    chk_outs(tag, e_diff, e_bout, e_zero, e_ovf);
    @(negedge clk);
    chk({tag, ".done_pulse"}, 16'(done), 16'd0);
    chk_outs({tag, ".hold"}, e_diff, e_bout, e_zero, e_ovf);
  endtask

  initial begin
    int dones;
    logic exp_done;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("rst.busy", 16'(busy), 16'd0);
    chk("rst.done", 16'(done), 16'd0);
    chk_outs("rst", 8'h00, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic and boundary operations
    op("basic", 8'h5A, 8'h23, 8'h37, 1'b0, 1'b0, 1'b0);
    op("wrap",  8'h00, 8'hFF, 8'h01, 1'b1, 1'b0, 1'b0);
    op("equal", 8'h10, 8'h10, 8'h00, 1'b0, 1'b1, 1'b0);
    op("small", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b0);
    op("sovf",  8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, OVF_ON);

    // Start pulse in busy cycle 3 is ignored
    start = 1'b1; a = 8'h80; b = 8'h01;
    @(negedge clk);
    start = 1'b0;
    for (int i = 1; i <= int'(W); i++) begin
      if (i == 3) begin
        start = 1'b1; a = 8'hFF; b = 8'h00;
      end else begin
        start = 1'b0;
      end
      chk("ign.busy", 16'(busy), 16'd1);
      @(negedge clk);
    end
    start = 1'b0;
    chk("ign.done", 16'(done), 16'd1);
    chk_outs("ign", 8'h7F, 1'b0, 1'b0, OVF_ON);
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    chk("ign.no_second", 16'(dones), 16'd0);

    // Reset in the 4th busy cycle aborts the run
    start = 1'b1; a = 8'h5A; b = 8'h23;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rstmid.busy_before", 16'(busy), 16'd1);
    rst_n = 1'b0;
    #1;
    chk("rstmid.busy", 16'(busy), 16'd0);
    chk("rstmid.done", 16'(done), 16'd0);
    chk_outs("rstmid", 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done || busy) dones++;
    end
    chk("rstmid.no_done", 16'(dones), 16'd0);
    op("after_rst", 8'h5A, 8'h23, 8'h37, 1'b0, 1'b0, 1'b0);

    // Level-held start: done every W+2 cycles; operands captured at accept
    start = 1'b1; a = 8'h5A; b = 8'h23;
    dones = 0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 3)  begin a = 8'h05; b = 8'h03; end
      if (i == 12) begin a = 8'h00; b = 8'hFF; end
      if (i == 30) start = 1'b0;
      exp_done = (i == 9) || (i == 19) || (i == 29);
      chk("held.done", 16'(done), 16'(exp_done));
      if (done) dones++;
      if (i == 9)  chk_outs("held1", 8'h37, 1'b0, 1'b0, 1'b0);
      if (i == 19) chk_outs("held2", 8'h02, 1'b0, 1'b0, 1'b0);
      if (i == 29) chk_outs("held3", 8'h01, 1'b1, 1'b0, 1'b0);
    end
    chk("held.count", 16'(dones), 16'd3);
    repeat (3) @(negedge clk);
    chk("held.idle", 16'(busy), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
